// File: rtl/pe_res_pack.sv
// Result-buffer to DDR packer: streams a run of buffer words out as DDR write beats,
// optionally zeroing negative lanes, through a 2-entry registered output FIFO.
module pe_res_pack #(
   parameter int BUF_DEPTH = 256,
   parameter int ADDR_W    = $clog2(BUF_DEPTH),
   parameter int LANES     = 4,
   parameter int LANE_W    = 16,
   parameter int DDR_W     = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      relu,
   input  logic [ADDR_W-1:0]         st_addr,
   input  logic [ADDR_W-1:0]         len_m1,
   output logic                      busy,
   output logic                      done,
   output logic                      buf_rd_en,
   output logic [ADDR_W-1:0]         buf_rd_addr,
   input  logic [LANES*LANE_W-1:0]   buf_rd_data,
   output logic [DDR_W-1:0]          ddr_data,
   output logic                      ddr_valid,
   input  logic                      ddr_ready
);

   generate
      if (DDR_W != LANES * LANE_W) begin : g_bad_width
         $error("pe_res_pack: DDR_W must equal LANES*LANE_W");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_rem;
   logic                r_relu;
   logic                r_rd_vld_p1;
   logic [1:0]          r_cnt;
   logic [DDR_W-1:0]    r_head;
   logic [DDR_W-1:0]    r_tail;
   logic                r_done;

   logic                w_pop;
   logic                w_push;
   logic [2:0]          w_occ;
   logic                w_rd_ok;
   logic                w_rd_en;
   logic                w_last_rd;
   logic                w_last_beat;
   logic                w_start_ok;
   logic                w_tail_wr;
   logic [DDR_W-1:0]    w_din_p1;

   function automatic logic [DDR_W-1:0] relu_clamp(input logic [DDR_W-1:0] word);
      logic [DDR_W-1:0]         res;
      logic signed [LANE_W-1:0] lane;
      res = word;
      for (int i = 0; i < LANES; i++) begin
         lane = word[i*LANE_W +: LANE_W];
         if (lane < 0)
            res[i*LANE_W +: LANE_W] = '0;
      end
      return res;
   endfunction

   // Read issue: count entries already held plus the one landing next cycle, net of a pop.
   assign w_pop       = (r_cnt != 2'd0) && ddr_ready;
   assign w_push      = r_rd_vld_p1;
   assign w_occ       = {1'b0, r_cnt} + {2'b00, r_rd_vld_p1} - {2'b00, w_pop};
   assign w_rd_ok     = (w_occ < 3'd2);
   assign w_rd_en     = (r_state == RUN) && w_rd_ok;
   assign w_last_rd   = w_rd_en && (r_rem == '0);
   assign w_last_beat = (r_state == DRAIN) && w_pop && (r_cnt == 2'd1) && !r_rd_vld_p1;
   assign w_start_ok  = (r_state == IDLE) && start;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start)       w_state_nxt = RUN;
         RUN:     if (w_last_rd)   w_state_nxt = DRAIN;
         DRAIN:   if (w_last_beat) w_state_nxt = IDLE;
         default:                  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Job parameters are captured once; the address walks with each issued read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr <= '0;
         r_rem  <= '0;
         r_relu <= 1'b0;
      end else if (w_start_ok) begin
         r_addr <= st_addr;
         r_rem  <= len_m1;
         r_relu <= relu;
      end else if (w_rd_en) begin
         r_addr <= (r_addr == ADDR_W'(BUF_DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
         r_rem  <= r_rem - ADDR_W'(1);
      end
   end

   // ---- stage p1: buffer data returns, optional clamp, FIFO entry ----
   assign w_din_p1 = r_relu ? relu_clamp(buf_rd_data) : buf_rd_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_vld_p1 <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_rd_vld_p1 <= w_rd_en;
         r_done      <= w_last_beat;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= 2'd0;
         r_head <= '0;
      end else begin
         case (r_cnt)
            2'd0: begin
               if (w_push) begin
                  r_head <= w_din_p1;
                  r_cnt  <= 2'd1;
               end
            end
            2'd1: begin
               if (w_push && w_pop) begin
                  r_head <= w_din_p1;
               end else if (w_push) begin
                  r_cnt <= 2'd2;
               end else if (w_pop) begin
                  r_cnt <= 2'd0;
               end
            end
            default: begin
               if (w_pop) begin
                  r_head <= r_tail;
                  r_cnt  <= w_push ? 2'd2 : 2'd1;
               end
            end
         endcase
      end
   end

   // Second slot only ever holds data behind a valid head, so it needs no reset.
   assign w_tail_wr = w_push && (((r_cnt == 2'd1) && !w_pop) || ((r_cnt == 2'd2) && w_pop));

   always_ff @(posedge clk) begin
      if (w_tail_wr)
         r_tail <= w_din_p1;
   end

   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign buf_rd_en   = w_rd_en;
   assign buf_rd_addr = r_addr;
   assign ddr_data    = r_head;
   assign ddr_valid   = (r_cnt != 2'd0);

endmodule

// File: tb/tb_pe_res_pack.sv
// Bench for pe_res_pack: table of jobs with hand-derived timing, plus a mid-job
// reset / ignored-start sequence.
module tb_pe_res_pack;

   localparam int AW = 8;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          relu = 1'b0;
   logic [AW-1:0] st_addr = '0;
   logic [AW-1:0] len_m1 = '0;
   logic          busy, done, buf_rd_en, ddr_valid;
   logic [AW-1:0] buf_rd_addr;
   logic [DW-1:0] buf_rd_data = '0;
   logic [DW-1:0] ddr_data;
   logic          ddr_ready = 1'b0;

   logic [DW-1:0] mem [256];

   int errs = 0;
   int checks = 0;

   pe_res_pack #(.BUF_DEPTH(256), .ADDR_W(AW), .LANES(4), .LANE_W(16), .DDR_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .relu(relu),
      .st_addr(st_addr), .len_m1(len_m1), .busy(busy), .done(done),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (buf_rd_en)
         buf_rd_data <= mem[buf_rd_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] clamp(input logic [63:0] w);
      logic [63:0] r;
      r = w;
      for (int i = 0; i < 4; i++)
         if (w[i*16+15]) r[i*16 +: 16] = 16'h0000;
      return r;
   endfunction

   function automatic logic [63:0] exp_word(input logic [7:0] a, input bit r);
      return r ? clamp(mem[a]) : mem[a];
   endfunction

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  len;
      bit          relu;
      bit          rnd;
      int          done_lat;
      logic [7:0]  last_addr;
      bit          chk_data;
      logic [63:0] first_data;
   } vec_t;

   task automatic run_job(input vec_t v);
      int          c, nrd, nbt, last_hs;
      bit          seen_done, stalled;
      logic [63:0] hold;
      logic [7:0]  last_a;
      st_addr = v.addr;
      len_m1  = v.len;
      relu    = v.relu;
      start   = 1'b1;
      @(posedge clk);
      seen_done = 0; stalled = 0; nrd = 0; nbt = 0; last_hs = 0; last_a = 8'h00; hold = '0;
      for (c = 1; c <= 400 && !seen_done; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start   = 1'b0;
            st_addr = 8'hAA;
            len_m1  = 8'h55;
            relu    = ~v.relu;
         end
         ddr_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (done) begin
            seen_done = 1;
            chk("busy_at_done", 64'(busy), 64'd0);
            if (v.rnd) chk("done_lat", 64'(c), 64'(last_hs + 1));
            else       chk("done_lat", 64'(c), 64'(v.done_lat));
         end else begin
            chk("busy", 64'(busy), 64'd1);
            if (buf_rd_en) begin
               if (nrd == 0) chk("first_rd_cycle", 64'(c), 64'd1);
               chk("rd_addr", 64'(buf_rd_addr), 64'(8'(v.addr + 8'(nrd))));
               last_a = buf_rd_addr;
               nrd++;
            end
            if (stalled) begin
               chk("valid_hold", 64'(ddr_valid), 64'd1);
               chk("stall_hold", ddr_data, hold);
            end
            if (ddr_valid) begin
               if (nbt == 0 && !v.rnd) chk("first_beat_cycle", 64'(c), 64'd3);
               if (ddr_ready) begin
                  chk("beat_data", ddr_data, exp_word(8'(v.addr + 8'(nbt)), v.relu));
                  if (nbt == 0 && v.chk_data) chk("relu_vec", ddr_data, v.first_data);
                  nbt++;
                  last_hs = c;
                  stalled = 0;
               end else begin
                  stalled = 1;
                  hold = ddr_data;
               end
            end
            chk("fifo_bound", 64'((nrd - nbt) <= 2), 64'd1);
         end
      end
      chk("done_seen", 64'(seen_done), 64'd1);
      chk("n_reads", 64'(nrd), 64'(v.len) + 64'd1);
      chk("n_beats", 64'(nbt), 64'(v.len) + 64'd1);
      chk("last_rd_addr", 64'(last_a), 64'(v.last_addr));
   endtask

   vec_t vecs [6];

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = {8'hA5, 8'(i), 8'(i), 8'h3C, 16'(i * 257), 16'h8000 | 16'(i)};
      mem[8'h40] = {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8001};

      vecs[0] = '{8'h10, 8'd3,   1'b0, 1'b0, 7,   8'h13, 1'b0, 64'h0};
      vecs[1] = '{8'hFE, 8'd3,   1'b0, 1'b0, 7,   8'h01, 1'b0, 64'h0};
      vecs[2] = '{8'h40, 8'd0,   1'b1, 1'b0, 4,   8'h40, 1'b1, 64'h0000_0000_7FFF_0000};
      vecs[3] = '{8'h20, 8'd7,   1'b0, 1'b1, 0,   8'h27, 1'b0, 64'h0};
      vecs[4] = '{8'h80, 8'd5,   1'b1, 1'b0, 9,   8'h85, 1'b0, 64'h0};
      vecs[5] = '{8'h00, 8'd255, 1'b0, 1'b0, 259, 8'hFF, 1'b0, 64'h0};

      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy",   64'(busy), 64'd0);
      chk("rst_done",   64'(done), 64'd0);
      chk("rst_rd_en",  64'(buf_rd_en), 64'd0);
      chk("rst_valid",  64'(ddr_valid), 64'd0);
      chk("rst_rd_addr", 64'(buf_rd_addr), 64'd0);
      chk("rst_data",   ddr_data, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++)
         run_job(vecs[i]);

      // Second start during a job is ignored, then reset lands mid-job.
      st_addr = 8'h30; len_m1 = 8'd7; relu = 1'b0; ddr_ready = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      #1 chk("mj_rd0", 64'(buf_rd_addr), 64'h30);
      @(negedge clk);
      start = 1'b1; st_addr = 8'h90; len_m1 = 8'd0;
      #1 chk("mj_rd1", 64'(buf_rd_addr), 64'h31);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("mj_ignored", 64'(buf_rd_addr), 64'h32);
      chk("mj_busy", 64'(busy), 64'd1);
      chk("mj_beat0", ddr_data, mem[8'h30]);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mr_busy",   64'(busy), 64'd0);
      chk("mr_done",   64'(done), 64'd0);
      chk("mr_rd_en",  64'(buf_rd_en), 64'd0);
      chk("mr_valid",  64'(ddr_valid), 64'd0);
      chk("mr_rd_addr", 64'(buf_rd_addr), 64'd0);
      chk("mr_data",   ddr_data, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1;
         chk("mr_no_done", 64'(done), 64'd0);
         chk("mr_idle", 64'(busy), 64'd0);
      end
      run_job('{8'h50, 8'd1, 1'b0, 1'b0, 5, 8'h51, 1'b0, 64'h0});

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
